// File: rtl/pipemem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pipemem_arbiter
// Description : Shares a single-port synchronous data memory between the
//               pipeline MEM stage and an auxiliary requester. Sequences
//               two-cycle loads, stalls the pipeline while the port is busy,
//               and gives the CPU fixed priority with a starvation override
//               that forces an aux grant after STARVE_LIMIT denied cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipemem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 3
) (
    input  logic        clock,
    input  logic        reset,
    // pipeline MEM stage
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    // auxiliary requester
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    output logic        aux_gnt,
    output logic        aux_rvalid,
    output logic [31:0] aux_rdata,
    // data memory
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_RDATA = 2'd1,
        AUX_RDATA = 2'd2
    } state_t;

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] starve_cnt;
    logic          force_aux;
    logic          issue_cpu;
    logic          issue_aux;

    // Aux has waited long enough: it beats the CPU this cycle
    assign force_aux = aux_req && (starve_cnt == LIMIT);

    // Pick the winner of the memory port and the state that follows.
    // Outputs decode from the registered state plus the current requests so
    // a store or aux write completes in the cycle it is presented. Reset
    // suppresses every issue so nothing reaches memory while it is asserted.
    always_comb begin
        issue_cpu  = 1'b0;
        issue_aux  = 1'b0;
        cpu_stall  = 1'b0;
        state_next = IDLE;
        if (!reset) begin
            case (state)
                CPU_RDATA: begin
                    // cpu_req still belongs to the load being completed; the
                    // port is free for aux this cycle
                    if (aux_req) begin
                        issue_aux = 1'b1;
                    end
                end
                default: begin
                    if (cpu_req && !force_aux) begin
                        issue_cpu = 1'b1;
                        cpu_stall = !cpu_we;
                    end else if (aux_req) begin
                        issue_aux = 1'b1;
                        cpu_stall = cpu_req;
                    end
                end
            endcase
            if (issue_cpu && !cpu_we) begin
                state_next = CPU_RDATA;
            end else if (issue_aux && !aux_we) begin
                state_next = AUX_RDATA;
            end
        end
    end

    assign aux_gnt   = issue_aux;
    assign mem_en    = issue_cpu || issue_aux;
    assign mem_we    = issue_cpu ? cpu_we    : (issue_aux ? aux_we    : 1'b0);
    assign mem_addr  = issue_cpu ? cpu_addr  : (issue_aux ? aux_addr  : 32'd0);
    assign mem_wdata = issue_cpu ? cpu_wdata : (issue_aux ? aux_wdata : 32'd0);

    // Read data returns one cycle after issue; steer it to whoever issued it
    assign aux_rvalid = !reset && (state == AUX_RDATA);
    assign aux_rdata  = aux_rvalid ? mem_rdata : 32'd0;
    assign cpu_rdata  = (!reset && (state == CPU_RDATA)) ? mem_rdata : 32'd0;

    // State register and saturating count of consecutive denied aux cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state <= state_next;
            if (!aux_req || issue_aux) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire
